// File: rtl/regfile_hilo.sv
// 32x32 GPR file with HI/LO registers, write-through bypass on every read port,
// and a wrapping debug counter of committed GPR writes.
module regfile_hilo #(
    parameter int WB_TO_RF_WD = 38,
    parameter int HILO_WD     = 67
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [HILO_WD-1:0]     mul_div_to_rf,
    input  logic [4:0]             raddr1,
    input  logic [4:0]             raddr2,
    output logic [31:0]            rdata1,
    output logic [31:0]            rdata2,
    output logic [31:0]            hi_rdata,
    output logic [31:0]            lo_rdata,
    output logic [15:0]            wr_count
);

    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        hi_we;
    logic        lo_we;
    logic        hilo_en;

    assign we       = wb_to_rf_bus[37];
    assign waddr    = wb_to_rf_bus[36:32];
    assign wdata    = wb_to_rf_bus[31:0];
    assign hi_wdata = mul_div_to_rf[66:35];
    assign lo_wdata = mul_div_to_rf[34:3];
    assign hi_we    = mul_div_to_rf[2];
    assign lo_we    = mul_div_to_rf[1];
    assign hilo_en  = mul_div_to_rf[0];

    logic [31:0] gpr_q [32];
    logic [31:0] gpr_d [32];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic gpr_wr;
    logic hi_wr;
    logic lo_wr;

    // Write strobes are suppressed during reset so neither storage nor bypass sees them.
    assign gpr_wr = !rst && we && (waddr != 5'd0);
    assign hi_wr  = !rst && hilo_en && hi_we;
    assign lo_wr  = !rst && hilo_en && lo_we;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            gpr_d[i] = rst ? 32'd0 : gpr_q[i];
        end
        hi_d       = rst ? 32'd0 : hi_q;
        lo_d       = rst ? 32'd0 : lo_q;
        wr_count_d = rst ? 16'd0 : wr_count_q;
        if (gpr_wr) begin
            gpr_d[waddr] = wdata;
            wr_count_d   = wr_count_q + 16'd1;
        end
        if (hi_wr) begin
            hi_d = hi_wdata;
        end
        if (lo_wr) begin
            lo_d = lo_wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            gpr_q[i] <= gpr_d[i];
        end
        hi_q       <= hi_d;
        lo_q       <= lo_d;
        wr_count_q <= wr_count_d;
    end

    // Register 0 is hardwired to zero, independent of what storage holds.
    always_comb begin
        rdata1 = gpr_q[raddr1];
        rdata2 = gpr_q[raddr2];
        if (gpr_wr && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
        if (gpr_wr && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
        if (raddr1 == 5'd0) begin
            rdata1 = 32'd0;
        end
        if (raddr2 == 5'd0) begin
            rdata2 = 32'd0;
        end
        hi_rdata = hi_wr ? hi_wdata : hi_q;
        lo_rdata = lo_wr ? lo_wdata : lo_q;
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed self-checking bench for regfile_hilo: bypass, zero register,
// HI/LO enables, reset priority and write-counter wrap.
module tb_regfile_hilo;

    logic        clk;
    logic        rst;
    logic [37:0] wb_to_rf_bus;
    logic [66:0] mul_div_to_rf;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;
    logic [15:0] wr_count;

    int errors = 0;
    int checks = 0;

    regfile_hilo #(
        .WB_TO_RF_WD(38),
        .HILO_WD(67)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_to_rf_bus(wb_to_rf_bus),
        .mul_div_to_rf(mul_div_to_rf),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .rdata1(rdata1),
        .rdata2(rdata2),
        .hi_rdata(hi_rdata),
        .lo_rdata(lo_rdata),
        .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] gpr_bus(input logic w, input logic [4:0] a, input logic [31:0] d);
        return {w, a, d};
    endfunction

    function automatic logic [66:0] hilo_bus(input logic [31:0] h, input logic [31:0] l,
                                             input logic hwe, input logic lwe, input logic en);
        return {h, l, hwe, lwe, en};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before touching inputs again.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        wb_to_rf_bus  = '0;
        mul_div_to_rf = '0;
        raddr1        = 5'd0;
        raddr2        = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check_output($sformatf("reset_rd1_r%0d", i), rdata1, 32'h0);
            check_output($sformatf("reset_rd2_r%0d", 31 - i), rdata2, 32'h0);
        end
        check_output("reset_hi", hi_rdata, 32'h0);
        check_output("reset_lo", lo_rdata, 32'h0);
        check_output("reset_wr_count", {16'h0, wr_count}, 32'h0);

        // Write r5 with bypass on both ports, then read back from storage.
        wb_to_rf_bus = gpr_bus(1'b1, 5'd5, 32'hDEADBEEF);
        raddr1 = 5'd5;
        raddr2 = 5'd5;
        #1;
        check_output("bypass_rd1_r5", rdata1, 32'hDEADBEEF);
        check_output("bypass_rd2_r5", rdata2, 32'hDEADBEEF);
        check_output("count_before_edge", {16'h0, wr_count}, 32'h0);
        tick();
        wb_to_rf_bus = '0;
        #1;
        check_output("stored_rd1_r5", rdata1, 32'hDEADBEEF);
        check_output("count_after_r5", {16'h0, wr_count}, 32'h1);

        // Writes to r0 are discarded and not counted.
        wb_to_rf_bus = gpr_bus(1'b1, 5'd0, 32'h12345678);
        raddr2 = 5'd0;
        #1;
        check_output("r0_bypass_rd2", rdata2, 32'h0);
        tick();
        wb_to_rf_bus = '0;
        #1;
        check_output("r0_stored_rd2", rdata2, 32'h0);
        check_output("count_after_r0", {16'h0, wr_count}, 32'h1);

        // Preload LO so the next step can show it is left alone.
        mul_div_to_rf = hilo_bus(32'h0, 32'h11112222, 1'b0, 1'b1, 1'b1);
        #1;
        check_output("lo_bypass", lo_rdata, 32'h11112222);
        check_output("hi_no_bypass", hi_rdata, 32'h0);
        tick();
        mul_div_to_rf = hilo_bus(32'hAAAA0000, 32'h0000BBBB, 1'b1, 1'b0, 1'b1);
        #1;
        check_output("hi_bypass", hi_rdata, 32'hAAAA0000);
        check_output("lo_hold_bypass", lo_rdata, 32'h11112222);
        tick();
        mul_div_to_rf = '0;
        #1;
        check_output("hi_stored", hi_rdata, 32'hAAAA0000);
        check_output("lo_stored", lo_rdata, 32'h11112222);

        // hilo_en low blocks the HI write and its bypass.
        mul_div_to_rf = hilo_bus(32'h00000001, 32'h00000002, 1'b1, 1'b1, 1'b0);
        #1;
        check_output("hilo_dis_hi_bypass", hi_rdata, 32'hAAAA0000);
        check_output("hilo_dis_lo_bypass", lo_rdata, 32'h11112222);
        tick();
        mul_div_to_rf = '0;
        #1;
        check_output("hilo_dis_hi", hi_rdata, 32'hAAAA0000);
        check_output("hilo_dis_lo", lo_rdata, 32'h11112222);

        // GPR and HI/LO writes in the same cycle both commit.
        wb_to_rf_bus  = gpr_bus(1'b1, 5'd9, 32'h00000099);
        mul_div_to_rf = hilo_bus(32'h00001234, 32'h00005678, 1'b1, 1'b1, 1'b1);
        raddr1 = 5'd9;
        raddr2 = 5'd5;
        tick();
        wb_to_rf_bus  = '0;
        mul_div_to_rf = '0;
        #1;
        check_output("dual_gpr_r9", rdata1, 32'h00000099);
        check_output("dual_r5_kept", rdata2, 32'hDEADBEEF);
        check_output("dual_hi", hi_rdata, 32'h00001234);
        check_output("dual_lo", lo_rdata, 32'h00005678);
        check_output("dual_count", {16'h0, wr_count}, 32'h2);

        // Back-to-back writes to r3: each visible via bypass, last one wins.
        raddr1 = 5'd3;
        raddr2 = 5'd3;
        wb_to_rf_bus = gpr_bus(1'b1, 5'd3, 32'hAAAAAAAA);
        #1;
        check_output("b2b_first_bypass", rdata1, 32'hAAAAAAAA);
        tick();
        wb_to_rf_bus = gpr_bus(1'b1, 5'd3, 32'hBBBBBBBB);
        #1;
        check_output("b2b_second_bypass", rdata2, 32'hBBBBBBBB);
        tick();
        wb_to_rf_bus = '0;
        #1;
        check_output("b2b_last_wins", rdata1, 32'hBBBBBBBB);
        check_output("b2b_count", {16'h0, wr_count}, 32'h4);

        // A bubble leaves everything unchanged.
        tick();
        check_output("bubble_count", {16'h0, wr_count}, 32'h4);
        check_output("bubble_r3", rdata1, 32'hBBBBBBBB);

        // Reset beats a simultaneous write and disables bypass.
        wb_to_rf_bus = gpr_bus(1'b1, 5'd7, 32'h00007777);
        tick();
        raddr1 = 5'd7;
        rst = 1'b1;
        wb_to_rf_bus  = gpr_bus(1'b1, 5'd7, 32'hFFFFFFFF);
        mul_div_to_rf = hilo_bus(32'hCAFECAFE, 32'hBEEFBEEF, 1'b1, 1'b1, 1'b1);
        #1;
        check_output("rst_no_bypass_r7", rdata1, 32'h00007777);
        check_output("rst_no_bypass_hi", hi_rdata, 32'h00001234);
        check_output("rst_no_bypass_lo", lo_rdata, 32'h00005678);
        tick();
        rst = 1'b0;
        wb_to_rf_bus  = '0;
        mul_div_to_rf = '0;
        #1;
        check_output("rst_r7_zero", rdata1, 32'h0);
        check_output("rst_r3_zero", rdata2, 32'h0);
        check_output("rst_hi_zero", hi_rdata, 32'h0);
        check_output("rst_lo_zero", lo_rdata, 32'h0);
        check_output("rst_count_zero", {16'h0, wr_count}, 32'h0);

        // First write right after reset commits with no idle cycle.
        raddr1 = 5'd2;
        wb_to_rf_bus = gpr_bus(1'b1, 5'd2, 32'h00000022);
        tick();
        wb_to_rf_bus = '0;
        #1;
        check_output("post_rst_write", rdata1, 32'h00000022);
        check_output("post_rst_count", {16'h0, wr_count}, 32'h1);

        // Drive the counter to 0xFFFF, then one more write wraps it.
        $display("[TB] running counter wrap sequence");
        for (int i = 0; i < 65534; i++) begin
            wb_to_rf_bus = gpr_bus(1'b1, 5'((i % 31) + 1), 32'(i));
            tick();
        end
        wb_to_rf_bus = '0;
        #1;
        check_output("count_ffff", {16'h0, wr_count}, 32'h0000FFFF);
        raddr2 = 5'd31;
        wb_to_rf_bus = gpr_bus(1'b1, 5'd31, 32'h31313131);
        tick();
        wb_to_rf_bus = '0;
        #1;
        check_output("count_wrap", {16'h0, wr_count}, 32'h0);
        check_output("wrap_r31", rdata2, 32'h31313131);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 Parameter WB_TO_RF_WD, default 38, width of the writeback-to-register-file bus.
REQ-002 Parameter HILO_WD, default 67, width of the writeback-to-HI/LO bus.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wb_to_rf_bus  input  WB_TO_RF_WD  packed {we[37], waddr[36:32], wdata[31:0]}.
REQ-006 mul_div_to_rf  input  HILO_WD  packed {hi_wdata[66:35], lo_wdata[34:3], hi_we[2], lo_we[1], hilo_en[0]}.
REQ-007 raddr1, raddr2  input  5 each  GPR read addresses.
REQ-008 rdata1, rdata2  output  32 each  GPR read data.
REQ-009 hi_rdata, lo_rdata  output  32 each  HI/LO read data.
REQ-010 wr_count  output  16  count of committed GPR writes (debug).

Function
REQ-011 Storage: 32 x 32-bit GPRs; one 32-bit HI; one 32-bit LO.
REQ-012 GPR write: on rising clk, if we=1 and waddr!=0, GPR[waddr] <= wdata.
REQ-013 Writes with waddr=0 are discarded; GPR[0] reads 0 at all times.
REQ-014 GPR reads are combinational; read latency 0 cycles.
REQ-015 Write-through bypass: if we=1, waddr!=0, and raddrN==waddr, rdataN = wdata in the same cycle, not the stored value.
REQ-016 Bypass applies independently to both read ports; both ports may bypass the same write.
REQ-017 HI write: on rising clk, if hilo_en=1 and hi_we=1, HI <= hi_wdata.
REQ-018 LO write: on rising clk, if hilo_en=1 and lo_we=1, LO <= lo_wdata.
REQ-019 hilo_en=0 blocks both HI and LO writes regardless of hi_we/lo_we.
REQ-020 HI/LO bypass: if hilo_en=1 and hi_we=1, hi_rdata = hi_wdata combinationally; same rule for LO with lo_we.
REQ-021 A GPR write and a HI/LO write in the same cycle both commit; the two paths are independent.
REQ-022 wr_count increments by 1 on each committed GPR write (we=1, waddr!=0); wraps 0xFFFF -> 0x0000.
REQ-023 An all-zero bus (pipeline bubble) writes nothing and leaves wr_count unchanged.
REQ-024 Back-to-back writes to one address: the last write wins; each write is readable via bypass in its own cycle and from storage in the following cycle.

Reset
REQ-025 While rst=1 at a rising edge, all GPRs, HI, LO, and wr_count <= 0.
REQ-026 Reset overrides simultaneous writes: a write presented in a cycle with rst=1 is dropped.
REQ-027 Bypass is disabled while rst=1; rdata1/2 and hi_rdata/lo_rdata show stored (zeroed after the edge) values.
REQ-028 After reset deasserts, the first write commits on the next rising edge; no idle cycles are needed.

Verification
REQ-029 Reset then read all 32 addresses -> every rdata = 0x00000000; hi/lo = 0; wr_count = 0.
REQ-030 Write we=1, waddr=5, wdata=0xDEADBEEF with raddr1=5 in the same cycle -> rdata1=0xDEADBEEF before the edge; after the edge, with bus idle, rdata1 still 0xDEADBEEF; wr_count=1.
REQ-031 Write waddr=0, wdata=0x12345678, raddr2=0 -> rdata2=0 both before and after the edge; wr_count unchanged.
REQ-032 mul_div_to_rf with hi=0xAAAA0000, lo=0x0000BBBB, hi_we=1, lo_we=0, hilo_en=1 -> HI=0xAAAA0000, LO keeps its prior value; repeat with hilo_en=0 and hi=0x1 -> HI unchanged.
REQ-033 rst=1 together with we=1, waddr=7, wdata=0xFFFFFFFF -> GPR[7]=0 after the edge; wr_count=0.
REQ-034 Preload wr_count to 0xFFFF through 65535 writes, then one more write -> wr_count=0x0000.
